block_streamer: RTL
===================

Name: block_streamer

Overview:
- Reader-side counterpart of the cache word-replace path.
- Accepts one full cache block through a valid/ready handshake, buffers it, and emits it one WORD_SIZE word per beat on a valid/ready output stream.
- Sits between the cache data array and the memory write-back / refill-forward path.
- Used for dirty-line eviction and for critical-word forwarding to the CPU side.

Parameters:
- WORD_SIZE, 32, bits per word.
- BLOCK_SIZE, 512, bits per block; must equal WORD_SIZE*NUM_SEGMENTS.
- NUM_SEGMENTS, 16, words per block.
- NUM_SEGMENTS_LOG, 4, log2(NUM_SEGMENTS).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- blk_valid  input  1  block offered.
- blk_ready  output  1  block accepted when blk_valid&&blk_ready.
- blk_data  input  BLOCK_SIZE  block contents, word i at [i*WORD_SIZE +: WORD_SIZE].
- blk_offset  input  NUM_SEGMENTS_LOG  index of first word to emit.
- word_valid  output  1  word_data valid.
- word_ready  input  1  downstream accepts a word when word_valid&&word_ready.
- word_data  output  WORD_SIZE  current word.
- word_index  output  NUM_SEGMENTS_LOG  block index of word_data.
- word_last  output  1  current word is the final beat of the block.
- busy  output  1  a block is held (state STREAM).

Behaviour:
- Reset: state=IDLE, beat count=0, pointer=0; word_valid=0, word_last=0, busy=0, word_data=0, word_index=0. blk_ready=1 in the first cycle after reset.
- State IDLE:
  - blk_ready=1, word_valid=0.
  - On blk handshake: capture blk_data into the buffer, pointer<=blk_offset, count<=0, go to STREAM.
- State STREAM:
  - word_valid=1.
  - word_data=buffer word[pointer]; word_index=pointer.
  - word_last=(count==NUM_SEGMENTS-1).
- Word handshake:
  - pointer<=pointer+1 modulo NUM_SEGMENTS (wraps 15->0); count<=count+1.
  - If word_last, return to IDLE.
- Latency: block accepted in cycle N gives first word_valid in cycle N+1. With word_ready held high, one word per cycle and 16 beats back-to-back.
- Back-pressure: when word_ready=0, word_data, word_index and word_last hold stable and word_valid stays 1. A valid word is never dropped or changed.
- Overlap:
  - blk_ready = IDLE || (word_valid && word_ready && word_last).
  - A new block may be accepted in the same cycle as the last-word handshake. The FSM then stays in STREAM with a reloaded pointer/count and no bubble.
- Block offer while streaming (not last beat): blk_ready=0, so the block is not captured; the upstream holds it.
- Arithmetic:
  - pointer is NUM_SEGMENTS_LOG bits with natural wrap.
  - count is NUM_SEGMENTS_LOG bits; word_last is decoded from it.
  - No overflow possible.
- Reset mid-stream: synchronous return to IDLE. Remaining words are discarded and word_valid=0 the next cycle.
- Word extraction: indexed part-select on the buffer. No per-index case list.

Optional Feature:
- Macro: BLOCK_STREAMER_CRITICAL_WORD_FIRST_EN.
- Defined: behaviour as above; the stream starts at blk_offset and wraps.
- Undefined: blk_offset is ignored, pointer loads 0 on capture, and words are emitted 0..15 in order; word_last occurs on index 15.

Decomposition:
- Shared package cache_pkg:
  - WORD_SIZE, BLOCK_SIZE, NUM_SEGMENTS, NUM_SEGMENTS_LOG defaults.
  - Typedefs word_t, block_t, seg_idx_t.
  - Streamer state enum {ST_IDLE, ST_STREAM}.
- One natural sub-module, block_word_select: combinational selection of word[pointer] from block_t. It is the read-side mirror of the word-replace function and is reusable by the cache read-hit path.

Test Plan:
- Reset, then blk_data word i = 32'hA000_0000+i, blk_offset=0, word_ready=1:
  - words A0000000..A000000F on consecutive cycles.
  - word_last only on beat 16.
  - first word_valid exactly 1 cycle after the blk handshake.
- Same block, blk_offset=13, macro defined:
  - indices 13,14,15,0,1,…,12.
  - word_last with word_index=12.
  - Macro undefined: indices 0..15.
- word_ready toggled 1,0,0,1 during beats 3-4: word_data/word_index held stable while stalled; no word skipped or duplicated; 16 total handshakes.
- Second block (words 32'hB000_0000+i) held valid during stream 1: blk_ready=1 only on stream 1's last-beat handshake; B0000000 appears the next cycle with no idle bubble.
- Assert rst at beat 7: next cycle word_valid=0, busy=0, blk_ready=1. A new block then streams from its own offset with count restarted.
- blk_valid=0 for 20 cycles after reset: word_valid stays 0 and blk_ready stays 1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry, word/block typedefs and streamer state encoding.
// Imported by block_word_select and block_streamer.
package cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int NUM_SEGMENTS     = 16;
    localparam int NUM_SEGMENTS_LOG = 4;
    localparam int BLOCK_SIZE       = WORD_SIZE * NUM_SEGMENTS;

    typedef logic [WORD_SIZE-1:0]        word_t;
    typedef logic [BLOCK_SIZE-1:0]       block_t;
    typedef logic [NUM_SEGMENTS_LOG-1:0] seg_idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } stream_state_e;

endpackage

// File: rtl/block_word_select.sv
// Combinational read of word[idx_i] from a cache block.
// Ports: block_i (block), idx_i (word index), word_o (selected word).
module block_word_select
    import cache_pkg::*;
#(
    parameter int WORD_SIZE_P        = WORD_SIZE,
    parameter int NUM_SEGMENTS_P     = NUM_SEGMENTS,
    parameter int NUM_SEGMENTS_LOG_P = NUM_SEGMENTS_LOG
) (
    input  logic [WORD_SIZE_P*NUM_SEGMENTS_P-1:0] block_i,
    input  logic [NUM_SEGMENTS_LOG_P-1:0]         idx_i,
    output logic [WORD_SIZE_P-1:0]                word_o
);

    assign word_o = block_i[idx_i*WORD_SIZE_P +: WORD_SIZE_P];

endmodule

// File: rtl/block_streamer.sv
// Buffers one cache block and emits it one word per beat (valid/ready).
// Ports: clk, rst (sync, active-high); blk_valid/blk_ready/blk_data/
// blk_offset block input; word_valid/word_ready/word_data/word_index/
// word_last word output; busy = block held.
// Macro BLOCK_STREAMER_CRITICAL_WORD_FIRST_EN: start at blk_offset and wrap;
// otherwise blk_offset is ignored and words go out 0..NUM_SEGMENTS-1.
module block_streamer
    import cache_pkg::*;
#(
    parameter int WORD_SIZE_P        = WORD_SIZE,
    parameter int NUM_SEGMENTS_P     = NUM_SEGMENTS,
    parameter int NUM_SEGMENTS_LOG_P = NUM_SEGMENTS_LOG,
    parameter int BLOCK_SIZE_P       = WORD_SIZE_P * NUM_SEGMENTS_P
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blk_valid,
    output logic                          blk_ready,
    input  logic [BLOCK_SIZE_P-1:0]       blk_data,
    input  logic [NUM_SEGMENTS_LOG_P-1:0] blk_offset,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [WORD_SIZE_P-1:0]        word_data,
    output logic [NUM_SEGMENTS_LOG_P-1:0] word_index,
    output logic                          word_last,
    output logic                          busy
);

    localparam logic [NUM_SEGMENTS_LOG_P-1:0] LAST_CNT =
        NUM_SEGMENTS_LOG_P'(NUM_SEGMENTS_P - 1);

    stream_state_e                 state_q, state_d;
    logic [BLOCK_SIZE_P-1:0]       buf_q, buf_d;
    logic [NUM_SEGMENTS_LOG_P-1:0] ptr_q, ptr_d;
    logic [NUM_SEGMENTS_LOG_P-1:0] cnt_q, cnt_d;
    logic [NUM_SEGMENTS_LOG_P-1:0] start_ptr;
    logic [WORD_SIZE_P-1:0]        sel_word;
    logic                          streaming;

`ifdef BLOCK_STREAMER_CRITICAL_WORD_FIRST_EN
    assign start_ptr = blk_offset;
`else
    logic unused_offset;
    assign unused_offset = ^blk_offset;
    assign start_ptr     = '0;
`endif

    block_word_select #(
        .WORD_SIZE_P       (WORD_SIZE_P),
        .NUM_SEGMENTS_P    (NUM_SEGMENTS_P),
        .NUM_SEGMENTS_LOG_P(NUM_SEGMENTS_LOG_P)
    ) u_sel (
        .block_i(buf_q),
        .idx_i  (ptr_q),
        .word_o (sel_word)
    );

    assign streaming  = (state_q == ST_STREAM);
    assign busy       = streaming;
    assign word_data  = streaming ? sel_word : '0;
    assign word_index = streaming ? ptr_q : '0;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        blk_ready  = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                blk_ready = 1'b1;
            end
            ST_STREAM: begin
                word_valid = 1'b1;
                word_last  = (cnt_q == LAST_CNT);
                if (word_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (word_last) begin
                        // Last beat leaving: a waiting block may load now.
                        blk_ready = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (blk_valid && blk_ready) begin
            buf_d   = blk_data;
            ptr_d   = start_ptr;
            cnt_d   = '0;
            state_d = ST_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
